clock_time_ctrl: RTL and testbench
==================================

// Module: clock_time_ctrl
// PURPOSE
//  Sequencer for the digital-clock counter chain (seconds/minutes/hours counters).
//  In RUN it generates the cascaded count enables from a 1 Hz tick.
//  In EDIT it freezes the chain and lets the user edit shadow HH/MM/SS with inc/dec pulses.
//  On commit it loads all three counters in one cycle through their set/s_* inputs.
//  Sits between the button debouncers/1 Hz divider and the three counters.
// PARAMETERS
//  TIMEOUT_S  30  seconds (tick_1hz count) with no button press before EDIT aborts to RUN; 0 disables
//  MAX_HH     23  hour wrap limit
//  MAX_MS     59  minute/second wrap limit
// PORTS
//  clk       in   1  system clock
//  rst       in   1  asynchronous, active-high reset
//  tick_1hz  in   1  one-cycle pulse, once per second
//  btn_mode  in   1  debounced one-cycle pulse: enter edit / advance field
//  btn_inc   in   1  debounced one-cycle pulse: increment edited field
//  btn_dec   in   1  debounced one-cycle pulse: decrement edited field
//  cur_hh    in   8  live hour count, binary 0..23
//  cur_mm    in   8  live minute count, binary 0..59
//  cur_ss    in   8  live second count, binary 0..59
//  ena_ss    out  1  seconds counter enable
//  ena_mm    out  1  minutes counter enable
//  ena_hh    out  1  hours counter enable
//  set_tm    out  1  one-cycle load strobe to all three counters
//  s_hh      out  8  hour load value / edit display value
//  s_mm      out  8  minute load value / edit display value
//  s_ss      out  8  second load value / edit display value
//  edit_fld  out  2  field under edit: 0=none, 1=HH, 2=MM, 3=SS (drives display blink)
// BEHAVIOUR
//  Reset: state RUN; shadows, timeout counter and all outputs are 0.
//  States: RUN -> E_HH -> E_MM -> E_SS -> COMMIT -> RUN. Transitions are on btn_mode, except COMMIT->RUN, which is unconditional after 1 cycle.
//  Enables are combinational from registered state, so they have zero latency:
//  - ena_ss = RUN & tick_1hz
//  - ena_mm = ena_ss & cur_ss==MAX_MS
//  - ena_hh = ena_mm & cur_mm==MAX_MS
//  - All enables are 0 in every other state. The clock freezes while editing.
//  RUN + btn_mode: shadows <= cur_hh/mm/ss (same edge), next state E_HH. A tick arriving in that same cycle is consumed: its enable fires and the counters advance.
//  E_xx + btn_inc: field +1; MAX wraps to 0.
//  E_xx + btn_dec: field -1; 0 wraps to MAX.
//  Only the field under edit changes.
//  inc and dec asserted in the same cycle: no change.
//  btn_mode together with inc/dec: mode wins; inc/dec are ignored that cycle.
//  E_SS + btn_mode -> COMMIT. In COMMIT, set_tm=1 for exactly one cycle with s_* = shadows. Counters show the new value from the next edge. Then RUN.
//  Timeout:
//  - The counter clears on entering edit and on any button pulse, and increments on tick_1hz while in E_xx.
//  - When it reaches TIMEOUT_S, go to RUN with no commit. set_tm stays 0 and the counters keep their pre-edit value.
//  s_* are registered shadows: they hold their last value in RUN and are valid whenever set_tm=1.
//  edit_fld = 1/2/3 in E_HH/E_MM/E_SS; 0 in RUN and COMMIT.
//  Out-of-range cur_* captured at edit entry (>MAX) are clamped to MAX in the shadow.
//  Reset mid-edit or in COMMIT returns immediately to RUN, with set_tm=0 and no partial load.
//  All arithmetic is 8-bit unsigned. Wrap compares use == against the parameters; there is no carry beyond the field.
// STRUCTURE
//  Shared package clock_pkg:
//  - state enum ctrl_st_t {RUN, E_HH, E_MM, E_SS, COMMIT}
//  - field codes FLD_NONE/HH/MM/SS
//  - constants MAX_HH=23, MAX_MS=59, used by this block and the counters
//  One sub-module wrap_updown (val, max, inc, dec -> next):
//  - combinational wrap-around +/-1
//  - instantiated once per shadow field
//  The FSM, timeout counter and enable cascade stay in this module.
// TESTING
//  1 cur=23:59:59, RUN, tick_1hz pulse -> ena_ss=ena_mm=ena_hh=1 in the same cycle, set_tm=0.
//  2 cur=12:34:56; mode; inc x13; mode; dec x35; mode; mode
//    -> shadow HH 12->23->01 (wraps through 0)
//    -> MM 34->59 (wraps through 0)
//    -> set_tm one cycle with s=01:59:56, back to RUN.
//  3 In E_MM, inc and dec asserted in the same cycle -> s_mm unchanged.
//    btn_mode together with inc -> advance to E_SS, s_mm unchanged.
//  4 TIMEOUT_S=3; in E_HH with no buttons, 3 ticks -> RUN on the 3rd tick.
//    set_tm never asserted; enables resume on the next tick.
//  5 In E_SS: rst pulse -> asynchronously RUN, edit_fld=0, outputs 0, no set_tm.
//    In RUN, tick held every cycle -> ena_ss tracks tick.
//  6 In RUN, btn_mode and tick_1hz in the same cycle with cur_ss=10 -> ena_ss=1 that cycle, shadow ss=10, state E_HH.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and limits for the clock sequencer and the HH/MM/SS counter chain.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        E_HH   = 3'd1,
        E_MM   = 3'd2,
        E_SS   = 3'd3,
        COMMIT = 3'd4
    } ctrl_st_t;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HH   = 2'd1;
    localparam logic [1:0] FLD_MM   = 2'd2;
    localparam logic [1:0] FLD_SS   = 2'd3;

    localparam logic [7:0] MAX_HH = 8'd23;
    localparam logic [7:0] MAX_MS = 8'd59;

    // Live counts can be out of range after a glitch; editing starts from a legal value.
    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] mx);
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Button/tick/count inputs and enable/load/display outputs of the clock sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a plain level or one-cycle pulse.
interface clock_time_ctrl_if;

    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [7:0] cur_hh;
    logic [7:0] cur_mm;
    logic [7:0] cur_ss;
    logic       ena_ss;
    logic       ena_mm;
    logic       ena_hh;
    logic       set_tm;
    logic [7:0] s_hh;
    logic [7:0] s_mm;
    logic [7:0] s_ss;
    logic [1:0] edit_fld;

    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_dec, cur_hh, cur_mm, cur_ss,
        input  ena_ss, ena_mm, ena_hh, set_tm, s_hh, s_mm, s_ss, edit_fld
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_dec, cur_hh, cur_mm, cur_ss,
        output ena_ss, ena_mm, ena_hh, set_tm, s_hh, s_mm, s_ss, edit_fld
    );

endinterface

// File: rtl/clock_time_ctrl_wrap_updown.sv
// Wrap-around +/-1 of one 8-bit time field between 0 and max.
// Latency: combinational.
// Backpressure: none; inc and dec together leave the value unchanged.
module wrap_updown (
    input  logic [7:0] val,
    input  logic [7:0] max,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] next
);

    always_comb begin
        next = val;
        if (inc && !dec) begin
            next = (val == max) ? 8'd0 : val + 8'd1;
        end else if (dec && !inc) begin
            next = (val == 8'd0) ? max : val - 8'd1;
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// Run/edit/commit sequencer for the HH:MM:SS counter chain with edit timeout.
// Latency: enables are combinational off registered state; load and display registered.
// Backpressure: none; button and tick pulses are acted on in the cycle they arrive.
module clock_time_ctrl #(
    parameter int unsigned TIMEOUT_S = 30,
    parameter logic [7:0]  MAX_HH    = clock_pkg::MAX_HH,
    parameter logic [7:0]  MAX_MS    = clock_pkg::MAX_MS
) (
    input  logic              clk,
    input  logic              rst,
    clock_time_ctrl_if.slave  bus
);

    import clock_pkg::*;

    localparam logic [15:0] TO_LIM = TIMEOUT_S[15:0];
    localparam bit          TO_EN  = (TIMEOUT_S != 0);

    ctrl_st_t    state;
    logic [7:0]  sh_hh, sh_mm, sh_ss;
    logic [7:0]  nx_hh, nx_mm, nx_ss;
    logic [15:0] to_cnt;
    logic        set_tm_q;
    logic [1:0]  edit_fld_q;
    logic        ed_step;
    logic        to_hit;
    logic        ena_ss_w, ena_mm_w;

    // inc/dec are dropped on a mode press; mode wins.
    assign ed_step = ~bus.btn_mode;

    wrap_updown u_wrap_hh (
        .val  (sh_hh),
        .max  (MAX_HH),
        .inc  (ed_step & (state == E_HH) & bus.btn_inc),
        .dec  (ed_step & (state == E_HH) & bus.btn_dec),
        .next (nx_hh)
    );

    wrap_updown u_wrap_mm (
        .val  (sh_mm),
        .max  (MAX_MS),
        .inc  (ed_step & (state == E_MM) & bus.btn_inc),
        .dec  (ed_step & (state == E_MM) & bus.btn_dec),
        .next (nx_mm)
    );

    wrap_updown u_wrap_ss (
        .val  (sh_ss),
        .max  (MAX_MS),
        .inc  (ed_step & (state == E_SS) & bus.btn_inc),
        .dec  (ed_step & (state == E_SS) & bus.btn_dec),
        .next (nx_ss)
    );

    assign ena_ss_w   = (state == RUN) & bus.tick_1hz;
    assign ena_mm_w   = ena_ss_w & (bus.cur_ss == MAX_MS);
    assign bus.ena_ss = ena_ss_w;
    assign bus.ena_mm = ena_mm_w;
    assign bus.ena_hh = ena_mm_w & (bus.cur_mm == MAX_MS);

    assign to_hit = TO_EN && bus.tick_1hz && ((to_cnt + 16'd1) == TO_LIM);

    assign bus.set_tm   = set_tm_q;
    assign bus.edit_fld = edit_fld_q;
    assign bus.s_hh     = sh_hh;
    assign bus.s_mm     = sh_mm;
    assign bus.s_ss     = sh_ss;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            sh_hh      <= 8'd0;
            sh_mm      <= 8'd0;
            sh_ss      <= 8'd0;
            to_cnt     <= 16'd0;
            set_tm_q   <= 1'b0;
            edit_fld_q <= FLD_NONE;
        end else begin
            case (state)
                RUN: begin
                    set_tm_q <= 1'b0;
                    if (bus.btn_mode) begin
                        sh_hh      <= clamp8(bus.cur_hh, MAX_HH);
                        sh_mm      <= clamp8(bus.cur_mm, MAX_MS);
                        sh_ss      <= clamp8(bus.cur_ss, MAX_MS);
                        to_cnt     <= 16'd0;
                        state      <= E_HH;
                        edit_fld_q <= FLD_HH;
                    end
                end
                E_HH, E_MM, E_SS: begin
                    if (bus.btn_mode) begin
                        to_cnt <= 16'd0;
                        if (state == E_HH) begin
                            state      <= E_MM;
                            edit_fld_q <= FLD_MM;
                        end else if (state == E_MM) begin
                            state      <= E_SS;
                            edit_fld_q <= FLD_SS;
                        end else begin
                            state      <= COMMIT;
                            set_tm_q   <= 1'b1;
                            edit_fld_q <= FLD_NONE;
                        end
                    end else if (bus.btn_inc || bus.btn_dec) begin
                        sh_hh  <= nx_hh;
                        sh_mm  <= nx_mm;
                        sh_ss  <= nx_ss;
                        to_cnt <= 16'd0;
                    end else if (to_hit) begin
                        // Abandon the edit: no load, counters keep their frozen value.
                        state      <= RUN;
                        edit_fld_q <= FLD_NONE;
                        to_cnt     <= 16'd0;
                    end else if (bus.tick_1hz) begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                COMMIT: begin
                    state    <= RUN;
                    set_tm_q <= 1'b0;
                end
                default: begin
                    state      <= RUN;
                    set_tm_q   <= 1'b0;
                    edit_fld_q <= FLD_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: directed scenarios plus random buttons/ticks against a
// phase-based reference model that also plays the role of the three counters.
module tb_clock_time_ctrl;

    localparam int TO = 3;

    logic clk = 1'b0;
    logic rst;

    clock_time_ctrl_if bus();

    clock_time_ctrl #(.TIMEOUT_S(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: phase 0=run,1..3=editing field,4=commit; shadows and counters as ints.
    int ph;
    int sh [3];
    int cur[3];
    int to_c;
    int mx [3] = '{23, 59, 59};
    bit tick, mode, inc, dec;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.tick_1hz = tick;
        bus.btn_mode = mode;
        bus.btn_inc  = inc;
        bus.btn_dec  = dec;
        bus.cur_hh   = cur[0][7:0];
        bus.cur_mm   = cur[1][7:0];
        bus.cur_ss   = cur[2][7:0];
    endtask

    task automatic compare_outputs();
        bit es, em, eh;
        es = (ph == 0) && tick;
        em = es && (cur[2] == 59);
        eh = em && (cur[1] == 59);
        check("ena_ss", bus.ena_ss, es);
        check("ena_mm", bus.ena_mm, em);
        check("ena_hh", bus.ena_hh, eh);
        check("set_tm", bus.set_tm, ph == 4);
        check("edit_fld", bus.edit_fld, (ph >= 1 && ph <= 3) ? ph : 0);
        check("s_hh", bus.s_hh, sh[0]);
        check("s_mm", bus.s_mm, sh[1]);
        check("s_ss", bus.s_ss, sh[2]);
    endtask

    task automatic model_advance();
        bit es, em, eh;
        int old_ph;
        es = (ph == 0) && tick;
        em = es && (cur[2] == 59);
        eh = em && (cur[1] == 59);
        old_ph = ph;
        case (ph)
            0: if (mode) begin
                for (int k = 0; k < 3; k++) sh[k] = (cur[k] > mx[k]) ? mx[k] : cur[k];
                ph = 1;
                to_c = 0;
            end
            1, 2, 3: begin
                if (mode) begin
                    ph = ph + 1;
                    to_c = 0;
                end else if (inc || dec) begin
                    if (inc && !dec) sh[ph-1] = (sh[ph-1] + 1) % (mx[ph-1] + 1);
                    else if (dec && !inc) sh[ph-1] = (sh[ph-1] + mx[ph-1]) % (mx[ph-1] + 1);
                    to_c = 0;
                end else if (tick) begin
                    to_c++;
                    if (to_c == TO) begin
                        ph = 0;
                        to_c = 0;
                    end
                end
            end
            default: ph = 0;
        endcase
        // Counter chain behaviour seen by the sequencer.
        if (old_ph == 4) for (int k = 0; k < 3; k++) cur[k] = sh[k];
        if (es) cur[2] = (cur[2] == 59) ? 0 : cur[2] + 1;
        if (em) cur[1] = (cur[1] == 59) ? 0 : cur[1] + 1;
        if (eh) cur[0] = (cur[0] == 23) ? 0 : cur[0] + 1;
    endtask

    task automatic step(input bit t, input bit m, input bit i, input bit d);
        @(negedge clk);
        tick = t; mode = m; inc = i; dec = d;
        drive();
        #1;
        compare_outputs();
        model_advance();
    endtask

    task automatic model_reset();
        ph = 0;
        to_c = 0;
        for (int k = 0; k < 3; k++) sh[k] = 0;
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        tick = 0; mode = 0; inc = 0; dec = 0;
        drive();
        #2 rst = 1'b1;
        #1;
        check({tag, "_edit_fld"}, bus.edit_fld, 0);
        check({tag, "_set_tm"}, bus.set_tm, 0);
        check({tag, "_s_sum"}, {8'd0, bus.s_hh, bus.s_mm, bus.s_ss}, 0);
        check({tag, "_ena_ss"}, bus.ena_ss, 0);
        #1 rst = 1'b0;
        model_reset();
    endtask

    int exp_mm;

    initial begin
        rst = 1'b1;
        tick = 0; mode = 0; inc = 0; dec = 0;
        cur = '{0, 0, 0};
        drive();
        model_reset();
        #2;
        check("rst_edit_fld", bus.edit_fld, 0);
        check("rst_set_tm", bus.set_tm, 0);
        check("rst_s_hh", bus.s_hh, 0);
        check("rst_s_ss", bus.s_ss, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: full carry on one tick
        cur = '{23, 59, 59};
        step(1, 0, 0, 0);
        check("t1_ena_hh", bus.ena_hh, 1);
        check("t1_ena_mm", bus.ena_mm, 1);
        check("t1_set_tm", bus.set_tm, 0);

        // 2: edit with wraps then commit
        cur = '{12, 34, 56};
        step(0, 1, 0, 0);
        repeat (13) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        repeat (35) step(0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("t2_set_tm", bus.set_tm, 1);
        check("t2_s_hh", bus.s_hh, 1);
        check("t2_s_mm", bus.s_mm, 59);
        check("t2_s_ss", bus.s_ss, 56);
        step(0, 0, 0, 0);
        check("t2_set_tm_off", bus.set_tm, 0);
        check("t2_loaded_ss", cur[2], 56);

        // 3: inc+dec together, then mode+inc
        exp_mm = cur[1];
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        check("t3_s_mm", bus.s_mm, exp_mm);
        check("t3_fld", bus.edit_fld, 3);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // 4: timeout after TO ticks
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("t4_still_edit", bus.edit_fld, 1);
        step(1, 0, 0, 0);
        check("t4_fld_run", bus.edit_fld, 0);
        check("t4_ena_ss", bus.ena_ss, 1);
        check("t4_set_tm", bus.set_tm, 0);

        // 5: async reset in E_SS, then tick held
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        async_reset("t5");
        repeat (4) begin
            step(1, 0, 0, 0);
            check("t5_ena_ss", bus.ena_ss, 1);
        end

        // 6: mode and tick together
        cur[2] = 10;
        step(1, 1, 0, 0);
        check("t6_ena_ss", bus.ena_ss, 1);
        step(1, 0, 0, 0);
        check("t6_s_ss", bus.s_ss, 10);
        check("t6_fld", bus.edit_fld, 1);
        check("t6_frozen", bus.ena_ss, 0);
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 0, 0);

        // Out-of-range capture clamps, then time out
        cur = '{30, 70, 99};
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("cl_s_hh", bus.s_hh, 23);
        check("cl_s_mm", bus.s_mm, 59);
        check("cl_s_ss", bus.s_ss, 59);
        repeat (3) step(1, 0, 0, 0);
        cur = '{5, 6, 7};

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                cur[0] = $urandom_range(0, 23);
                cur[1] = $urandom_range(0, 59);
                cur[2] = $urandom_range(0, 59);
            end
            if ($urandom_range(0, 999) == 0) async_reset("rnd_rst");
            step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
